// File: rtl/ray_column_caster.sv
// ray_column_caster
//
// Sequential grid raycaster. On each frame kick it casts one ray per
// screen column through an 8x8 colour map. For each column it writes one
// record (wall height, colour, face flag) into the external column buffer.
//
// Optional build macro: RAYCAST_SIDE_SHADE_EN
//   defined   - col_side marks walls that were entered through a horizontal
//               face (only the cell row changed on the hit step)
//   undefined - col_side is tied to 0 and no face-tracking state exists
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   start       one-cycle frame kick, ignored while busy
//   pos_x/y     player position, unsigned Q3.8 map cells
//   dir_x/y     view direction, signed Q1.8
//   plane_x/y   camera plane, signed Q1.8
//   grid_color  8x8 map, 2 bits per cell, cell i = y*8+x, 0 = empty
//   busy        frame in progress
//   done        one-cycle pulse after the last column write
//   col_we      column buffer write strobe
//   col_addr    column index being written
//   col_height  wall height in pixels, clamped to SCREEN_H
//   col_color   wall colour code (0 on a miss)
//   col_side    wall face flag
module ray_column_caster #(
  parameter int COLS_LOG2 = 6,
  parameter int SCREEN_H  = 480,
  parameter int HEIGHT_K  = 7680,
  parameter int MAX_STEPS = 255,
  parameter int OOB_COLOR = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [10:0]  pos_x,
  input  logic [10:0]  pos_y,
  input  logic [9:0]   dir_x,
  input  logic [9:0]   dir_y,
  input  logic [9:0]   plane_x,
  input  logic [9:0]   plane_y,
  input  logic [127:0] grid_color,
  output logic         busy,
  output logic         done,
  output logic         col_we,
  output logic [7:0]   col_addr,
  output logic [8:0]   col_height,
  output logic [1:0]   col_color,
  output logic         col_side
);

  localparam int COLS = 1 << COLS_LOG2;

  typedef enum logic [2:0] {IDLE, SETUP, MARCH, DIV, WRITE, NEXT} state_t;

  state_t state_q, state_d;

  logic [10:0]  pos_x_q, pos_y_q;
  logic [9:0]   dir_x_q, dir_y_q, plane_x_q, plane_y_q;
  logic [127:0] grid_q;
  logic [7:0]   col_q;
  logic [11:0]  rdx_q, rdy_q;
  logic [17:0]  acc_x_q, acc_y_q;
  logic [7:0]   t_q;
  logic [1:0]   hit_color_q;
  logic [7:0]   divisor_q;
  logic [15:0]  div_q;
  logic [7:0]   rem_q;
  logic [3:0]   div_cnt_q;

  logic signed [11:0] cam_base, camx;
  logic signed [21:0] prod_x, prod_y;
  logic [11:0]  rdx_d, rdy_d;
  logic [17:0]  next_x, next_y;
  logic [7:0]   t_next;
  logic         oob, hit, miss;
  logic [1:0]   cell_code;
  logic [8:0]   rem_sh, rem_new;
  logic         div_ge;
  logic [15:0]  quo_new;
  logic [8:0]   height_clamped;
  logic         unused_bits;

  // Ray direction for the current column: camx spans [-1, 1) across the
  // screen, scaled into Q1.8 before weighting the camera plane.
  assign cam_base = $signed({3'b000, col_q, 1'b0}) - $signed(12'(COLS));
  assign camx     = cam_base <<< (8 - COLS_LOG2);
  assign prod_x   = $signed({{12{plane_x_q[9]}}, plane_x_q}) * $signed({{10{camx[11]}}, camx});
  assign prod_y   = $signed({{12{plane_y_q[9]}}, plane_y_q}) * $signed({{10{camx[11]}}, camx});
  assign rdx_d    = {{2{dir_x_q[9]}}, dir_x_q} + prod_x[19:8];
  assign rdy_d    = {{2{dir_y_q[9]}}, dir_y_q} + prod_y[19:8];

  // One march step. The Q1.8 direction lands on a Q.12 accumulator, so each
  // step advances 1/16 of the ray direction.
  assign next_x    = acc_x_q + {{6{rdx_q[11]}}, rdx_q};
  assign next_y    = acc_y_q + {{6{rdy_q[11]}}, rdy_q};
  assign t_next    = t_q + 8'd1;
  assign oob       = (next_x[17:15] != 3'b000) || (next_y[17:15] != 3'b000);
  assign cell_code = grid_q[{next_y[14:12], next_x[14:12], 1'b0} +: 2];
  assign hit       = oob || (cell_code != 2'b00);
  assign miss      = !hit && (t_next == 8'(MAX_STEPS));

  // Restoring divider step: the dividend shifts out of div_q while the
  // quotient bits shift in behind it.
  assign rem_sh  = {rem_q, div_q[15]};
  assign div_ge  = rem_sh >= {1'b0, divisor_q};
  assign rem_new = div_ge ? (rem_sh - {1'b0, divisor_q}) : rem_sh;
  assign quo_new = {div_q[14:0], div_ge};
  assign height_clamped = (quo_new > 16'(SCREEN_H)) ? 9'(SCREEN_H) : quo_new[8:0];

  assign unused_bits = ^{prod_x[21:20], prod_x[7:0], prod_y[21:20], prod_y[7:0], rem_new[8]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and the strobes that follow directly from the state.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    col_we  = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = SETUP;
      SETUP: state_d = MARCH;
      MARCH: begin
        if (hit)       state_d = DIV;
        else if (miss) state_d = WRITE;
      end
      DIV:   if (div_cnt_q == 4'd15) state_d = WRITE;
      WRITE: begin
        col_we  = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        if (col_q == 8'(COLS - 1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SETUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: frame snapshot, march accumulators, divider and the
  // column record, which only changes when the next WRITE is set up.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      dir_x_q     <= '0;
      dir_y_q     <= '0;
      plane_x_q   <= '0;
      plane_y_q   <= '0;
      grid_q      <= '0;
      col_q       <= '0;
      rdx_q       <= '0;
      rdy_q       <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      t_q         <= '0;
      hit_color_q <= '0;
      divisor_q   <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      div_cnt_q   <= '0;
      col_addr    <= '0;
      col_height  <= '0;
      col_color   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pos_x_q   <= pos_x;
            pos_y_q   <= pos_y;
            dir_x_q   <= dir_x;
            dir_y_q   <= dir_y;
            plane_x_q <= plane_x;
            plane_y_q <= plane_y;
            grid_q    <= grid_color;
            col_q     <= '0;
          end
        end
        SETUP: begin
          rdx_q   <= rdx_d;
          rdy_q   <= rdy_d;
          acc_x_q <= {3'b000, pos_x_q, 4'b0000};
          acc_y_q <= {3'b000, pos_y_q, 4'b0000};
          t_q     <= '0;
        end
        MARCH: begin
          if (hit) begin
            hit_color_q <= oob ? 2'(OOB_COLOR) : cell_code;
            divisor_q   <= t_next;
            div_q       <= 16'(HEIGHT_K);
            rem_q       <= '0;
            div_cnt_q   <= '0;
          end else if (miss) begin
            col_addr   <= col_q;
            col_height <= '0;
            col_color  <= '0;
          end else begin
            acc_x_q <= next_x;
            acc_y_q <= next_y;
            t_q     <= t_next;
          end
        end
        DIV: begin
          div_q     <= quo_new;
          rem_q     <= rem_new[7:0];
          div_cnt_q <= div_cnt_q + 4'd1;
          if (div_cnt_q == 4'd15) begin
            col_addr   <= col_q;
            col_height <= height_clamped;
            col_color  <= hit_color_q;
          end
        end
        NEXT: begin
          if (col_q != 8'(COLS - 1)) col_q <= col_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef RAYCAST_SIDE_SHADE_EN
  logic hit_side_q;
  logic step_side;

  // Horizontal face only when the row changed but the column did not; a
  // diagonal entry counts as a vertical face.
  assign step_side = (next_y[17:12] != acc_y_q[17:12]) && (next_x[17:12] == acc_x_q[17:12]);

  // Face flag captured at the hit and published with the rest of the record.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_side_q <= 1'b0;
      col_side   <= 1'b0;
    end else begin
      if (state_q == MARCH && hit) hit_side_q <= step_side;
      if (state_q == MARCH && miss) col_side <= 1'b0;
      if (state_q == DIV && div_cnt_q == 4'd15) col_side <= hit_side_q;
    end
  end
`else
  assign col_side = 1'b0;
`endif

endmodule
